// File: rtl/irq_ctrl.sv
// -----------------------------------------------------------------------------
// irq_ctrl -- interrupt / exception controller for the five-stage pipeline.
//
// Prioritises NUM_IRQ edge-triggered interrupt lines plus the ID-stage
// exception flag, drives a request/take handshake toward the hazard/jump
// unit, records EPC and CAUSE, supplies the handler vector and exposes a
// small software register file.
//
// Optional feature: define IRQ_TIMER_EN to build the compare timer that
// feeds PENDING[0] (STATUS.TE, TIMER_CMP at addr 5, TIMER_CNT at addr 6).
//
// Ports
//   clk, reset      : system clock, synchronous active-high reset
//   irq_in          : interrupt lines, rising-edge sensitive
//   exc, exc_pc     : exception pulse from ID and the faulting PC
//   irq_take,take_pc: pipeline accepts the request; resume PC to save
//   eret            : return from handler
//   wr_en,addr,
//   wr_data,rd_data : register port (write at next edge, combinational read)
//   irq_req         : interrupt request (high while in REQ)
//   exc_out         : exception redirect (combinational from exc)
//   vector          : redirect target for irq_req / exc_out
//   epc             : saved return PC
//   dbg_state       : current FSM state (0 IDLE, 1 REQ, 2 SERVICE)
//
// Handshake: irq_req is a level request that stays high while a masked-in
// pending interrupt exists and GIE is set; the pipeline accepts it by
// asserting irq_take in a cycle where irq_req is high. The request may be
// withdrawn without a take if the source is masked/cleared or GIE drops.
// -----------------------------------------------------------------------------
module irq_ctrl #(
  parameter int          NUM_IRQ  = 8,
  parameter logic [31:0] VEC_BASE = 32'h8000_0040,
  parameter logic [31:0] EXC_VEC  = 32'h8000_0080
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               exc,
  input  logic [31:0]        exc_pc,
  input  logic               irq_take,
  input  logic [31:0]        take_pc,
  input  logic               eret,
  input  logic               wr_en,
  input  logic [2:0]         addr,
  input  logic [31:0]        wr_data,
  output logic [31:0]        rd_data,
  output logic               irq_req,
  output logic               exc_out,
  output logic [31:0]        vector,
  output logic [31:0]        epc,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               gie_q, gie_d;
  logic               df_q, df_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] irq_d_q, irq_d_d;
  logic [31:0]        epc_q, epc_d;
  logic [4:0]         cause_q, cause_d;

  // Per-cycle helpers
  logic [NUM_IRQ-1:0] active;
  logic [NUM_IRQ-1:0] lowest_oh;
  logic [4:0]         lowest_idx;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] take_clr;
  logic [NUM_IRQ-1:0] sw_clr;
  logic [NUM_IRQ-1:0] timer_set;
  logic               hw_epc_we;
  logic [31:0]        hw_epc_val;
  logic               hw_cause_we;
  logic [4:0]         hw_cause_val;
  logic               df_set;
  logic               te;

`ifdef IRQ_TIMER_EN
  logic               te_q, te_d;
  logic [31:0]        tcmp_q, tcmp_d;
  logic [31:0]        tcnt_q, tcnt_d;
`endif

  assign active = pending_q & mask_q;
  assign rise   = irq_in & ~irq_d_q;

  // Lowest-index active channel wins; scanning high to low leaves the
  // lowest set bit as the final assignment.
  always_comb begin
    lowest_idx = '0;
    lowest_oh  = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (active[i]) begin
        lowest_idx   = 5'(i);
        lowest_oh    = '0;
        lowest_oh[i] = 1'b1;
      end
    end
  end

  // FSM next state and handshake outputs
  always_comb begin
    state_d      = state_q;
    irq_req      = 1'b0;
    exc_out      = 1'b0;
    vector       = EXC_VEC;
    hw_epc_we    = 1'b0;
    hw_epc_val   = exc_pc;
    hw_cause_we  = 1'b0;
    hw_cause_val = 5'(NUM_IRQ);
    take_clr     = '0;
    df_set       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (exc) begin
          exc_out     = 1'b1;
          hw_epc_we   = 1'b1;
          hw_cause_we = 1'b1;
          state_d     = ST_SERVICE;
        end else if (gie_q && (|active)) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        irq_req = 1'b1;
        vector  = VEC_BASE + (32'(lowest_idx) << 2);
        if (exc) begin
          // An exception pre-empts the pending request outright.
          exc_out     = 1'b1;
          vector      = EXC_VEC;
          hw_epc_we   = 1'b1;
          hw_cause_we = 1'b1;
          state_d     = ST_SERVICE;
        end else if (!gie_q || !(|active)) begin
          state_d = ST_IDLE;
        end else if (irq_take) begin
          hw_epc_we    = 1'b1;
          hw_epc_val   = take_pc;
          hw_cause_we  = 1'b1;
          hw_cause_val = lowest_idx;
          take_clr     = lowest_oh;
          state_d      = ST_SERVICE;
        end
      end
      ST_SERVICE: begin
        // No nesting: an exception here is only recorded as a double fault.
        if (exc) df_set = 1'b1;
        if (eret) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef IRQ_TIMER_EN
  always_comb begin
    te_d      = te_q;
    tcmp_d    = tcmp_q;
    tcnt_d    = tcnt_q;
    timer_set = '0;
    if (te_q) begin
      if (tcnt_q == tcmp_q) begin
        tcnt_d       = '0;
        timer_set[0] = 1'b1;
      end else begin
        tcnt_d = tcnt_q + 32'd1;
      end
    end
    if (wr_en && (addr == 3'd0)) te_d   = wr_data[3];
    if (wr_en && (addr == 3'd5)) tcmp_d = wr_data;
    if (wr_en && (addr == 3'd6)) tcnt_d = wr_data;
  end
  assign te = te_q;
`else
  assign timer_set = '0;
  assign te        = 1'b0;
`endif

  // Register file updates; hardware captures override software writes.
  always_comb begin
    gie_d   = gie_q;
    mask_d  = mask_q;
    epc_d   = epc_q;
    cause_d = cause_q;
    irq_d_d = irq_in;
    sw_clr  = '0;
    df_d    = df_q;
    if (wr_en) begin
      case (addr)
        3'd0: begin
          gie_d = wr_data[0];
          if (wr_data[2]) df_d = 1'b0;
        end
        3'd1:    mask_d = wr_data[NUM_IRQ-1:0];
        3'd2:    sw_clr = wr_data[NUM_IRQ-1:0];
        3'd3:    epc_d  = wr_data;
        default: ;
      endcase
    end
    if (df_set)      df_d    = 1'b1;
    if (hw_epc_we)   epc_d   = hw_epc_val;
    if (hw_cause_we) cause_d = hw_cause_val;
    // A new edge (or timer hit) on a bit wins over any clear in the same cycle.
    pending_d = (pending_q & ~sw_clr & ~take_clr) | rise | timer_set;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      gie_q     <= 1'b0;
      df_q      <= 1'b0;
      mask_q    <= '0;
      pending_q <= '0;
      irq_d_q   <= '0;
      epc_q     <= '0;
      cause_q   <= '0;
`ifdef IRQ_TIMER_EN
      te_q      <= 1'b0;
      tcmp_q    <= 32'hFFFF_FFFF;
      tcnt_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      gie_q     <= gie_d;
      df_q      <= df_d;
      mask_q    <= mask_d;
      pending_q <= pending_d;
      irq_d_q   <= irq_d_d;
      epc_q     <= epc_d;
      cause_q   <= cause_d;
`ifdef IRQ_TIMER_EN
      te_q      <= te_d;
      tcmp_q    <= tcmp_d;
      tcnt_q    <= tcnt_d;
`endif
    end
  end

  always_comb begin
    rd_data = '0;
    case (addr)
      3'd0: rd_data = {28'd0, te, df_q, (state_q == ST_SERVICE), gie_q};
      3'd1: rd_data = 32'(mask_q);
      3'd2: rd_data = 32'(pending_q);
      3'd3: rd_data = epc_q;
      3'd4: rd_data = 32'(cause_q);
`ifdef IRQ_TIMER_EN
      3'd5: rd_data = tcmp_q;
      3'd6: rd_data = tcnt_q;
`endif
      default: rd_data = '0;
    endcase
  end

  assign epc       = epc_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_irq_ctrl -- directed scenarios followed by random traffic, every cycle
// compared with a behavioural model of the controller's register/interrupt
// rules kept in this file.
// -----------------------------------------------------------------------------
module tb_irq_ctrl;

  localparam int          NUM_IRQ  = 8;
  localparam logic [31:0] VEC_BASE = 32'h8000_0040;
  localparam logic [31:0] EXC_VEC  = 32'h8000_0080;
`ifdef IRQ_TIMER_EN
  localparam bit HAS_TIMER = 1'b1;
`else
  localparam bit HAS_TIMER = 1'b0;
`endif
  localparam int S_IDLE = 0;
  localparam int S_REQ  = 1;
  localparam int S_SVC  = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset;
  logic [NUM_IRQ-1:0] irq_in;
  logic               exc;
  logic [31:0]        exc_pc;
  logic               irq_take;
  logic [31:0]        take_pc;
  logic               eret;
  logic               wr_en;
  logic [2:0]         addr;
  logic [31:0]        wr_data;
  logic [31:0]        rd_data;
  logic               irq_req;
  logic               exc_out;
  logic [31:0]        vector;
  logic [31:0]        epc;
  logic [1:0]         dbg_state;

  irq_ctrl #(.NUM_IRQ(NUM_IRQ), .VEC_BASE(VEC_BASE), .EXC_VEC(EXC_VEC)) dut (
    .clk(clk), .reset(reset), .irq_in(irq_in), .exc(exc), .exc_pc(exc_pc),
    .irq_take(irq_take), .take_pc(take_pc), .eret(eret), .wr_en(wr_en),
    .addr(addr), .wr_data(wr_data), .rd_data(rd_data), .irq_req(irq_req),
    .exc_out(exc_out), .vector(vector), .epc(epc), .dbg_state(dbg_state)
  );

  int checks   = 0;
  int failures = 0;
  bit check_on = 1'b0;

  // ---------------- reference model ----------------
  int                 m_state;
  bit                 m_gie, m_df, m_te;
  logic [NUM_IRQ-1:0] m_mask, m_pending, m_prev;
  logic [31:0]        m_epc, m_cause, m_cmp, m_cnt;

  function automatic int lowest(input logic [NUM_IRQ-1:0] v);
    for (int i = 0; i < NUM_IRQ; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic logic [31:0] model_rd(input logic [2:0] a);
    case (a)
      3'd0: return {28'd0, m_te & HAS_TIMER, m_df, m_state == S_SVC, m_gie};
      3'd1: return 32'(m_mask);
      3'd2: return 32'(m_pending);
      3'd3: return m_epc;
      3'd4: return m_cause;
      3'd5: return HAS_TIMER ? m_cmp : 32'd0;
      3'd6: return HAS_TIMER ? m_cnt : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] model_vector();
    if (exc && m_state != S_SVC) return EXC_VEC;
    if (m_state == S_REQ) return VEC_BASE + 32'(4 * lowest(m_pending & m_mask));
    return EXC_VEC;
  endfunction

  task automatic model_reset();
    m_state = S_IDLE; m_gie = 0; m_df = 0; m_te = 0;
    m_mask = '0; m_pending = '0; m_prev = '0;
    m_epc = '0; m_cause = '0; m_cmp = 32'hFFFF_FFFF; m_cnt = '0;
  endtask

  // Applies one clock edge using the inputs held during the cycle.
  task automatic model_step();
    logic [NUM_IRQ-1:0] rise, act, clr;
    int    ns;
    bit    cap, hit, df_clr, df_set;
    logic [31:0] cap_epc, cap_cause, cnt_next;
    if (reset) begin
      model_reset();
      return;
    end
    rise = irq_in & ~m_prev;
    act  = m_pending & m_mask;
    clr  = '0;
    ns   = m_state;
    cap  = 0; cap_epc = '0; cap_cause = '0;
    df_set = 0; df_clr = 0;
    if (m_state == S_IDLE || m_state == S_REQ) begin
      if (exc) begin
        ns = S_SVC; cap = 1; cap_epc = exc_pc; cap_cause = NUM_IRQ;
      end else if (m_state == S_IDLE) begin
        if (m_gie && act != 0) ns = S_REQ;
      end else if (!m_gie || act == 0) begin
        ns = S_IDLE;
      end else if (irq_take) begin
        ns = S_SVC; cap = 1; cap_epc = take_pc;
        cap_cause = lowest(act);
        clr[lowest(act)] = 1'b1;
      end
    end else begin
      if (exc) df_set = 1;
      if (eret) ns = S_IDLE;
    end
    hit = 0;
    cnt_next = m_cnt;
    if (HAS_TIMER && m_te) begin
      if (m_cnt == m_cmp) begin cnt_next = 0; hit = 1; end
      else cnt_next = m_cnt + 1;
    end
    if (wr_en) begin
      case (addr)
        3'd0: begin m_gie = wr_data[0]; if (HAS_TIMER) m_te = wr_data[3]; df_clr = wr_data[2]; end
        3'd1: m_mask = wr_data[NUM_IRQ-1:0];
        3'd2: clr = clr | wr_data[NUM_IRQ-1:0];
        3'd3: m_epc = wr_data;
        3'd5: if (HAS_TIMER) m_cmp = wr_data;
        3'd6: if (HAS_TIMER) cnt_next = wr_data;
        default: ;
      endcase
    end
    m_cnt = cnt_next;
    if (cap) begin m_epc = cap_epc; m_cause = cap_cause; end
    m_pending = (m_pending & ~clr) | rise | {{(NUM_IRQ-1){1'b0}}, hit};
    if (df_clr) m_df = 0;
    if (df_set) m_df = 1;
    m_prev  = irq_in;
    m_state = ns;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    #1;
    if (check_on) begin
      chk("m_irq_req", 32'(irq_req), 32'(m_state == S_REQ));
      chk("m_exc_out", 32'(exc_out), 32'(exc && m_state != S_SVC));
      chk("m_vector", vector, model_vector());
      chk("m_epc", epc, m_epc);
      chk("m_rd_data", rd_data, model_rd(addr));
    end
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    wr_en = 1'b1; addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [2:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(tag, rd_data, exp);
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; irq_in = '0; exc = 0; exc_pc = '0; irq_take = 0; take_pc = '0;
    eret = 0; wr_en = 0; addr = '0; wr_data = '0;
    model_reset();
    @(negedge clk);
    tick();
    tick();
    reset = 1'b0;
    check_on = 1'b1;

    // Reset values
    #1;
    chk("rst_irq_req", 32'(irq_req), 32'd0);
    chk("rst_vector", vector, EXC_VEC);
    chk("rst_epc", epc, 32'd0);
    for (int a = 0; a < 8; a++)
      rd("rst_rd", 3'(a), (HAS_TIMER && a == 5) ? 32'hFFFF_FFFF : 32'd0);

    // Two simultaneous rises, lowest index served first
    wr(3'd1, 32'h0C);
    wr(3'd0, 32'h1);
    irq_in = 8'h0C;
    tick();
    irq_in = '0; addr = 3'd2;
    #1;
    chk("pend_after_rise", rd_data, 32'h0C);
    chk("no_req_yet", 32'(irq_req), 32'd0);
    tick();
    #1;
    chk("req_two_later", 32'(irq_req), 32'd1);
    chk("vec_ch2", vector, 32'h8000_0048);
    irq_take = 1'b1; take_pc = 32'h100;
    tick();
    irq_take = 1'b0;
    #1;
    chk("epc_out_take", epc, 32'h100);
    rd("epc_take", 3'd3, 32'h100);
    rd("cause_take", 3'd4, 32'd2);
    rd("pend_after_take", 3'd2, 32'h08);
    rd("status_svc", 3'd0, 32'h3);

    // eret, then withdraw a request by masking
    eret = 1'b1;
    tick();
    eret = 1'b0;
    #1;
    chk("idle_after_eret", 32'(irq_req), 32'd0);
    chk("epc_kept", epc, 32'h100);
    tick();
    #1;
    chk("req_ch3", 32'(irq_req), 32'd1);
    chk("vec_ch3", vector, 32'h8000_004C);
    wr(3'd1, 32'h0);
    tick();
    #1;
    chk("idle_after_mask0", 32'(irq_req), 32'd0);
    rd("status_no_take", 3'd0, 32'h1);

    // Exception pre-empts REQ; second exception in SERVICE -> DF
    wr(3'd1, 32'h0C);
    tick();
    #1;
    chk("req_before_exc", 32'(irq_req), 32'd1);
    exc = 1'b1; exc_pc = 32'h40;
    #1;
    chk("exc_out_req", 32'(exc_out), 32'd1);
    chk("exc_vec", vector, EXC_VEC);
    tick();
    exc = 1'b0;
    rd("cause_exc", 3'd4, NUM_IRQ);
    rd("epc_exc", 3'd3, 32'h40);
    exc = 1'b1; exc_pc = 32'h99;
    #1;
    chk("exc_out_svc", 32'(exc_out), 32'd0);
    tick();
    exc = 1'b0;
    rd("status_df", 3'd0, 32'h7);
    #1;
    chk("epc_df", epc, 32'h40);
    wr(3'd0, 32'h5);
    rd("status_df_clr", 3'd0, 32'h3);
    eret = 1'b1;
    tick();
    eret = 1'b0;
    wr(3'd0, 32'h0);
    wr(3'd2, 32'hFF);
    tick();

    // Clear and new edge on the same bit in one cycle: set wins
    irq_in = 8'h20;
    wr(3'd2, 32'h20);
    irq_in = '0;
    rd("w1c_set_wins", 3'd2, 32'h20);
    wr(3'd2, 32'hFF);

`ifdef IRQ_TIMER_EN
    wr(3'd5, 32'd3);
    wr(3'd6, 32'd0);
    wr(3'd0, 32'h8);
    rd("tcnt0", 3'd6, 32'd0);
    rd("tcnt1", 3'd6, 32'd1);
    rd("tcnt2", 3'd6, 32'd2);
    rd("tcnt3", 3'd6, 32'd3);
    rd("tcnt_wrap", 3'd6, 32'd0);
    rd("timer_pend", 3'd2, 32'h1);
    wr(3'd0, 32'h0);
    wr(3'd2, 32'hFF);
`else
    wr(3'd6, 32'h1234);
    rd("tcnt_absent", 3'd6, 32'd0);
    wr(3'd5, 32'h5);
    rd("tcmp_absent", 3'd5, 32'd0);
`endif

    // Reset discards a request in flight
    wr(3'd1, 32'h0C);
    wr(3'd0, 32'h1);
    irq_in = 8'h04;
    tick();
    irq_in = '0;
    tick();
    #1;
    chk("req_before_reset", 32'(irq_req), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("reset_kills_req", 32'(irq_req), 32'd0);
    rd("reset_pend", 3'd2, 32'd0);
    rd("reset_mask", 3'd1, 32'd0);

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      reset    = ($urandom_range(0, 249) == 0);
      if ($urandom_range(0, 3) == 0) irq_in = NUM_IRQ'($urandom);
      exc      = ($urandom_range(0, 15) == 0);
      exc_pc   = $urandom;
      irq_take = ($urandom_range(0, 2) == 0);
      take_pc  = $urandom;
      eret     = ($urandom_range(0, 7) == 0);
      wr_en    = ($urandom_range(0, 3) == 0);
      addr     = 3'($urandom_range(0, 7));
      wr_data  = $urandom;
      if (addr == 3'd0) wr_data[0] = ($urandom_range(0, 3) != 0);
      if (addr == 3'd5) wr_data = $urandom_range(0, 20);
      tick();
    end
    reset = 1'b0; wr_en = 1'b0; exc = 1'b0; irq_take = 1'b0; eret = 1'b0;

    // ---------------- final report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
